// File: rtl/dispatch_stage_n_pkg.sv
// Shared configuration, encodings and helpers for the N-wide dispatch stage.
// The localparams below are the single source of the block configuration.
package dispatch_stage_n_pkg;

  localparam int DISPATCH_WIDTH = 2;
  localparam int SRC_PER_INST   = 2;
  localparam int CDB_PORTS      = 2;
  localparam int ALU_QUEUES     = 2;
  localparam int DATA_W         = 32;
  localparam int PREG_W         = 6;

  localparam int N_SRC     = DISPATCH_WIDTH * SRC_PER_INST;
  localparam int N_Q       = ALU_QUEUES + 2;
  localparam int MDU_Q     = ALU_QUEUES;
  localparam int LSU_Q     = ALU_QUEUES + 1;
  localparam int ALU_SEL_W = (ALU_QUEUES > 1) ? $clog2(ALU_QUEUES) : 1;

  typedef enum logic [1:0] {
    INST_ALU  = 2'b00,
    INST_MDU  = 2'b01,
    INST_LSU  = 2'b10,
    INST_NONE = 2'b11
  } inst_type_e;

  typedef struct packed {
    logic [N_Q-1:0][DISPATCH_WIDTH-1:0] choose;
    logic [N_SRC-1:0][DATA_W-1:0]       data;
    logic [N_SRC-1:0]                   data_valid;
    logic [N_SRC-1:0][PREG_W-1:0]       src_preg;
    logic [DISPATCH_WIDTH-1:0][PREG_W-1:0] preg;
  } dispatch_grp_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } cdb_hit_t;

  function automatic cdb_hit_t cdb_lookup(
    input logic [CDB_PORTS-1:0]        v,
    input logic [CDB_PORTS*PREG_W-1:0] p,
    input logic [CDB_PORTS*DATA_W-1:0] d,
    input logic [PREG_W-1:0]           src
  );
    cdb_hit_t r;
    r = '0;
    // Lowest matching port wins; later ports never overwrite an earlier hit.
    for (int c = 0; c < CDB_PORTS; c++) begin
      if (!r.hit && v[c] && (p[c*PREG_W +: PREG_W] == src)) begin
        r.hit  = 1'b1;
        r.data = d[c*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  function automatic logic [N_Q-1:0] queue_onehot(
    input inst_type_e        t,
    input logic [PREG_W-1:0] preg
  );
    logic [N_Q-1:0] oh;
    oh = {N_Q{1'b0}};
    case (t)
      INST_ALU: begin
        if (ALU_QUEUES > 1) oh[preg[ALU_SEL_W-1:0]] = 1'b1;
        else                oh[0] = 1'b1;
      end
      INST_MDU: oh[MDU_Q] = 1'b1;
      INST_LSU: oh[LSU_Q] = 1'b1;
      default:  oh = {N_Q{1'b0}};
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dispatch_stage_n_operand_resolve.sv
// One source operand: ARF/immediate, CDB forward or ROB result, plus its valid.
module dispatch_stage_n_operand_resolve
  import dispatch_stage_n_pkg::*;
(
  input  logic                        src_ready_i,
  input  logic                        use_imm_i,
  input  logic [DATA_W-1:0]           imm_i,
  input  logic [DATA_W-1:0]           arf_data_i,
  input  logic                        rob_complete_i,
  input  logic [DATA_W-1:0]           rob_data_i,
  input  logic [PREG_W-1:0]           src_preg_i,
  input  logic [CDB_PORTS-1:0]        cdb_valid_i,
  input  logic [CDB_PORTS*PREG_W-1:0] cdb_preg_i,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data_i,
  output logic [DATA_W-1:0]           data_o,
  output logic                        valid_o
);

  cdb_hit_t hit_s;

  // Operand mux: ready source first, then CDB forward, then ROB.
  always_comb begin
    hit_s = cdb_lookup(cdb_valid_i, cdb_preg_i, cdb_data_i, src_preg_i);
    if (src_ready_i) begin
      data_o = use_imm_i ? imm_i : arf_data_i;
    end else if (hit_s.hit) begin
      data_o = hit_s.data;
    end else begin
      data_o = rob_data_i;
    end
    valid_o = src_ready_i | hit_s.hit | rob_complete_i;
  end

endmodule

// File: rtl/dispatch_stage_n.sv
// N-wide dispatch stage with registered group and per-queue draining.
// Optional held-operand CDB wakeup: define DISPATCH_HOLD_WAKEUP_EN.
module dispatch_stage_n
  import dispatch_stage_n_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  input  logic [DISPATCH_WIDTH-1:0]          in_valid_i,
  output logic                               in_ready_o,
  input  logic [DISPATCH_WIDTH*2-1:0]        inst_type_i,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]   preg_i,
  input  logic [N_SRC*PREG_W-1:0]            src_preg_i,
  input  logic [N_SRC-1:0]                   src_ready_i,
  input  logic [N_SRC*DATA_W-1:0]            arf_data_i,
  input  logic [N_SRC-1:0]                   use_imm_i,
  input  logic [DISPATCH_WIDTH*DATA_W-1:0]   imm_i,
  input  logic [N_SRC-1:0]                   rob_complete_i,
  input  logic [N_SRC*DATA_W-1:0]            rob_data_i,
  input  logic [CDB_PORTS-1:0]               cdb_valid_i,
  input  logic [CDB_PORTS*PREG_W-1:0]        cdb_preg_i,
  input  logic [CDB_PORTS*DATA_W-1:0]        cdb_data_i,
  output logic [DISPATCH_WIDTH-1:0]          rob_valid_o,
  output logic [N_Q-1:0]                     q_valid_o,
  input  logic [N_Q-1:0]                     q_ready_i,
  output logic [N_Q*DISPATCH_WIDTH-1:0]      q_choose_o,
  output logic [N_SRC*DATA_W-1:0]            q_data_o,
  output logic [N_SRC-1:0]                   q_data_valid_o,
  output logic [N_SRC*PREG_W-1:0]            q_src_preg_o,
  output logic [DISPATCH_WIDTH*PREG_W-1:0]   q_preg_o
);

  localparam int W = DISPATCH_WIDTH;
  localparam int S = SRC_PER_INST;

  dispatch_grp_t                   grp_q, grp_d;
  logic [N_Q-1:0]                  qv_q, qv_d;
  logic [W-1:0]                    rob_q, rob_d;
  logic [N_SRC-1:0][DATA_W-1:0]    res_data_s;
  logic [N_SRC-1:0]                res_valid_s;
  logic [N_Q-1:0][W-1:0]           choose_s;
  logic                            accept_s;

  for (genvar n = 0; n < N_SRC; n++) begin : g_src
    dispatch_stage_n_operand_resolve u_res (
      .src_ready_i    (src_ready_i[n]),
      .use_imm_i      (use_imm_i[n]),
      .imm_i          (imm_i[(n/S)*DATA_W +: DATA_W]),
      .arf_data_i     (arf_data_i[n*DATA_W +: DATA_W]),
      .rob_complete_i (rob_complete_i[n]),
      .rob_data_i     (rob_data_i[n*DATA_W +: DATA_W]),
      .src_preg_i     (src_preg_i[n*PREG_W +: PREG_W]),
      .cdb_valid_i    (cdb_valid_i),
      .cdb_preg_i     (cdb_preg_i),
      .cdb_data_i     (cdb_data_i),
      .data_o         (res_data_s[n]),
      .valid_o        (res_valid_s[n])
    );
  end

  // A queue still holding an entry it cannot hand over blocks the next group.
  assign in_ready_o = !flush_i && ((qv_q & ~q_ready_i) == {N_Q{1'b0}});
  assign accept_s   = in_ready_o && (|in_valid_i);

  // Steering: per-slot queue selection, masked by slot valid.
  always_comb begin
    logic [N_Q-1:0] oh;
    oh       = {N_Q{1'b0}};
    choose_s = '0;
    for (int i = 0; i < W; i++) begin
      oh = queue_onehot(inst_type_e'(inst_type_i[2*i +: 2]), preg_i[i*PREG_W +: PREG_W]);
      for (int q = 0; q < N_Q; q++) begin
        choose_s[q][i] = oh[q] & in_valid_i[i];
      end
    end
  end

  // Next group state: flush, accept, or hold with per-queue drain.
  always_comb begin
`ifdef DISPATCH_HOLD_WAKEUP_EN
    cdb_hit_t wk;
    wk = '0;
`endif
    grp_d = grp_q;
    qv_d  = qv_q & ~q_ready_i;
    rob_d = {W{1'b0}};
    if (flush_i) begin
      qv_d = {N_Q{1'b0}};
    end else if (accept_s) begin
      for (int q = 0; q < N_Q; q++) begin
        qv_d[q] = |choose_s[q];
      end
      grp_d.choose     = choose_s;
      grp_d.data       = res_data_s;
      grp_d.data_valid = res_valid_s;
      grp_d.src_preg   = src_preg_i;
      grp_d.preg       = preg_i;
      rob_d            = in_valid_i;
    end else begin
`ifdef DISPATCH_HOLD_WAKEUP_EN
      for (int n = 0; n < N_SRC; n++) begin
        wk = cdb_lookup(cdb_valid_i, cdb_preg_i, cdb_data_i, grp_q.src_preg[n]);
        if (!grp_q.data_valid[n] && wk.hit) begin
          grp_d.data[n]       = wk.data;
          grp_d.data_valid[n] = 1'b1;
        end else begin
          grp_d.data[n]       = grp_q.data[n];
          grp_d.data_valid[n] = grp_q.data_valid[n];
        end
      end
`else
      grp_d = grp_q;
`endif
    end
  end

  // Group, queue-valid and ROB-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_q <= '0;
      qv_q  <= {N_Q{1'b0}};
      rob_q <= {W{1'b0}};
    end else begin
      grp_q <= grp_d;
      qv_q  <= qv_d;
      rob_q <= rob_d;
    end
  end

  assign q_valid_o      = qv_q;
  assign rob_valid_o    = rob_q;
  assign q_choose_o     = grp_q.choose;
  assign q_data_o       = grp_q.data;
  assign q_data_valid_o = grp_q.data_valid;
  assign q_src_preg_o   = grp_q.src_preg;
  assign q_preg_o       = grp_q.preg;

endmodule

// File: tb/tb_dispatch_stage_n.sv
// Directed bench for dispatch_stage_n with hand-computed expectations.
module tb_dispatch_stage_n;
  import dispatch_stage_n_pkg::*;

  logic clk = 1'b0;
  logic rst_n, flush_i, in_ready_o;
  logic [1:0]  in_valid_i, rob_valid_o;
  logic [3:0]  inst_type_i;
  logic [11:0] preg_i, q_preg_o;
  logic [23:0] src_preg_i, q_src_preg_o;
  logic [3:0]  src_ready_i, use_imm_i, rob_complete_i, q_data_valid_o;
  logic [127:0] arf_data_i, rob_data_i, q_data_o;
  logic [63:0] imm_i, cdb_data_i;
  logic [1:0]  cdb_valid_i;
  logic [11:0] cdb_preg_i;
  logic [3:0]  q_valid_o, q_ready_i;
  logic [7:0]  q_choose_o;

  int total = 0;
  int bad   = 0;

  dispatch_stage_n dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_type_i(inst_type_i), .preg_i(preg_i),
    .src_preg_i(src_preg_i), .src_ready_i(src_ready_i),
    .arf_data_i(arf_data_i), .use_imm_i(use_imm_i), .imm_i(imm_i),
    .rob_complete_i(rob_complete_i), .rob_data_i(rob_data_i),
    .cdb_valid_i(cdb_valid_i), .cdb_preg_i(cdb_preg_i), .cdb_data_i(cdb_data_i),
    .rob_valid_o(rob_valid_o), .q_valid_o(q_valid_o), .q_ready_i(q_ready_i),
    .q_choose_o(q_choose_o), .q_data_o(q_data_o),
    .q_data_valid_o(q_data_valid_o), .q_src_preg_o(q_src_preg_o),
    .q_preg_o(q_preg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush_i = 1'b0; in_valid_i = 2'b00; inst_type_i = 4'b1111; preg_i = 12'd0;
    src_preg_i = 24'd0; src_ready_i = 4'b0000; use_imm_i = 4'b0000;
    rob_complete_i = 4'b0000; arf_data_i = 128'd0; rob_data_i = 128'd0;
    imm_i = 64'd0; cdb_valid_i = 2'b00; cdb_preg_i = 12'd0; cdb_data_i = 64'd0;
  endtask

  task automatic slot(input int i, input logic [1:0] t, input logic [5:0] p);
    in_valid_i[i] = 1'b1;
    inst_type_i[2*i +: 2] = t;
    preg_i[6*i +: 6] = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    q_ready_i = 4'b1111;
    rst_n = 1'b0;
    step(); step();
    chk("rst_qvalid", q_valid_o, 4'b0000);
    chk("rst_rob", rob_valid_o, 2'b00);
    chk("rst_data", q_data_o[63:0], 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_inready", in_ready_o, 1'b1);
    step();
    chk("idle_noaccept", {rob_valid_o, q_valid_o}, 6'd0);

    // Steering: slot0 ALU preg5 -> ALU1, slot1 LSU preg8 -> LSU
    slot(0, 2'b00, 6'd5); slot(1, 2'b10, 6'd8);
    src_ready_i = 4'b1111; use_imm_i = 4'b0100;
    arf_data_i = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    imm_i = {32'hBEEF, 32'h0AAA};
    q_ready_i = 4'b0000;
    step();
    chk("steer_qvalid", q_valid_o, 4'b1010);
    chk("steer_choose", q_choose_o, 8'b1000_0100);
    chk("steer_rob", rob_valid_o, 2'b11);
    chk("steer_data", q_data_o, {32'h1003, 32'hBEEF, 32'h1001, 32'h1000});
    chk("steer_dvalid", q_data_valid_o, 4'b1111);
    chk("steer_preg", q_preg_o, {6'd8, 6'd5});
    idle();
    step();
    chk("hold_rob_pulse", rob_valid_o, 2'b00);
    chk("hold_qvalid", q_valid_o, 4'b1010);
    chk("hold_inready", in_ready_o, 1'b0);
    q_ready_i = 4'b1111;
    step();
    chk("drain_all", q_valid_o, 4'b0000);

    // Operand priority: CDB0 beats CDB1 beats ROB
    slot(0, 2'b00, 6'd0);
    rob_complete_i = 4'b0001; rob_data_i = {32'h0, 32'h0, 32'h55, 32'h11};
    src_preg_i = {6'd0, 6'd0, 6'd9, 6'd7};
    cdb_valid_i = 2'b11; cdb_preg_i = {6'd7, 6'd7}; cdb_data_i = {32'h22, 32'h33};
    step();
    chk("prio_cdb0", q_data_o[31:0], 32'h33);
    chk("prio_nohit_data", q_data_o[63:32], 32'h55);
    chk("prio_valid", q_data_valid_o[1:0], 2'b01);
    chk("prio_rob", rob_valid_o, 2'b01);
    chk("prio_src_preg", q_src_preg_o[11:0], {6'd9, 6'd7});
    cdb_valid_i = 2'b10;
    step();
    chk("prio_cdb1", q_data_o[31:0], 32'h22);

    // Independent drain: ALU0 + MDU, MDU held off
    idle();
    slot(0, 2'b00, 6'd2); slot(1, 2'b01, 6'd3);
    src_ready_i = 4'b1111;
    step();
    chk("drn_qvalid", q_valid_o, 4'b0101);
    idle();
    q_ready_i = 4'b1011;
    #1;
    chk("drn_inready0", in_ready_o, 1'b0);
    step();
    chk("drn_c1", q_valid_o, 4'b0100);
    step(); step();
    chk("drn_c3", q_valid_o, 4'b0100);
    chk("drn_inready3", in_ready_o, 1'b0);
    q_ready_i = 4'b1111;
    slot(0, 2'b10, 6'd1); slot(1, 2'b00, 6'd1);
    #1;
    chk("drn_inready_ok", in_ready_o, 1'b1);
    step();
    chk("drn_new_qvalid", q_valid_o, 4'b1010);
    chk("drn_new_rob", rob_valid_o, 2'b11);

    // Flush while held
    idle();
    q_ready_i = 4'b0000;
    step();
    chk("fl_held", q_valid_o, 4'b1010);
    flush_i = 1'b1; slot(0, 2'b00, 6'd0); slot(1, 2'b01, 6'd0);
    q_ready_i = 4'b1111;
    #1;
    chk("fl_inready", in_ready_o, 1'b0);
    step();
    chk("fl_qvalid", q_valid_o, 4'b0000);
    chk("fl_rob", rob_valid_o, 2'b00);

    // Held-operand wakeup
    idle();
    q_ready_i = 4'b0000;
    slot(0, 2'b00, 6'd0);
    src_preg_i = {6'd0, 6'd0, 6'd0, 6'd12};
    src_ready_i = 4'b0010;
    arf_data_i = {32'h0, 32'h0, 32'h77, 32'h0};
    step();
    chk("wk_init_valid", q_data_valid_o[1:0], 2'b10);
    idle();
    cdb_valid_i = 2'b01; cdb_preg_i = {6'd0, 6'd12}; cdb_data_i = {32'h0, 32'hABCD};
    step();
`ifdef DISPATCH_HOLD_WAKEUP_EN
    chk("wk_valid", q_data_valid_o[0], 1'b1);
    chk("wk_data", q_data_o[31:0], 32'hABCD);
`else
    chk("wk_valid", q_data_valid_o[0], 1'b0);
    chk("wk_data", q_data_o[31:0], 32'h0);
`endif
    chk("wk_other", q_data_o[63:32], 32'h77);
    chk("wk_hold_qvalid", q_valid_o, 4'b0001);

    // Reset while a group is held
    idle();
    rst_n = 1'b0;
    step();
    chk("rst2_qvalid", q_valid_o, 4'b0000);
    chk("rst2_data", q_data_o[63:0], 64'd0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
